run_monitor: RTL

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor.sv | 101 ++++++++++
 1 files changed

// File: rtl/run_monitor.sv
// Run monitor: holds a core in reset, lets it run until it halts or hits a cycle
// limit, then captures its result and the number of cycles it consumed.
module run_monitor #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RST_CYCLES = 10,
  parameter int unsigned RUN_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              halt,
  input  logic [DATA_W-1:0] result,
  output logic              core_rstn,
  output logic              busy,
  output logic              done,
  output logic              done_pulse,
  output logic              timeout,
  output logic [DATA_W-1:0] captured,
  output logic [CNT_W-1:0]  cycles
);

  localparam int unsigned      RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_e;

  state_e            state_q;
  logic [RST_W-1:0]  rstCnt_q;
  logic [CNT_W-1:0]  runCnt_q;
  logic              coreRstn_q;
  logic              busy_q;
  logic              done_q;
  logic              donePulse_q;
  logic              timeout_q;
  logic [DATA_W-1:0] captured_q;
  logic [CNT_W-1:0]  cycles_q;

  // Halt is tested before the limit so a halt on the final cycle is not a timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rstCnt_q    <= '0;
      runCnt_q    <= '0;
      coreRstn_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      donePulse_q <= 1'b0;
      timeout_q   <= 1'b0;
      captured_q  <= '0;
      cycles_q    <= '0;
    end else begin
      donePulse_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= RESET;
            rstCnt_q   <= '0;
            coreRstn_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
          end
        end
        RESET: begin
          if (rstCnt_q == RST_LAST) begin
            state_q    <= RUN;
            runCnt_q   <= '0;
            coreRstn_q <= 1'b1;
          end else begin
            rstCnt_q <= rstCnt_q + 1'b1;
          end
        end
        RUN: begin
          if (halt || (runCnt_q == RUN_LAST)) begin
            state_q     <= DONE;
            captured_q  <= result;
            cycles_q    <= runCnt_q + 1'b1;
            timeout_q   <= ~halt;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            donePulse_q <= 1'b1;
          end else begin
            runCnt_q <= runCnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_rstn  = coreRstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_pulse = donePulse_q;
  assign timeout    = timeout_q;
  assign captured   = captured_q;
  assign cycles     = cycles_q;

endmodule
